// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding and the load-use hazard predicate.
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_LIMIT = 255;
    localparam logic [4:0] ZERO_REGISTER = 5'd0;

    function automatic logic load_use_hit(
        input logic       valid,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt,
        input logic       mem_read,
        input logic       reg_write,
        input logic [4:0] wr
    );
        return valid & mem_read & reg_write
             & (wr != ZERO_REGISTER)
             & ((wr == rs) | (uses_rt & (wr == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_control_if.sv
// Decode/execute hazard inputs and pipeline control outputs.
// master drives the pipeline side, slave is the controller.
interface pipeline_hazard_control_if;

    logic       idValid;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUsesRt;
    logic       exMemRead;
    logic       exRegWrite;
    logic [4:0] exWriteRegister;
    logic       branchTaken;
    logic       memBusy;

    logic        pcWrite;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        exMemFlush;
    logic        idExBubble;
    logic [15:0] stallCount;
    logic [15:0] flushCount;
    logic        memTimeout;

    modport master (
        output idValid, idRs, idRt, idUsesRt,
        output exMemRead, exRegWrite, exWriteRegister,
        output branchTaken, memBusy,
        input  pcWrite, ifIdWrite,
        input  ifIdFlush, idExFlush, exMemFlush,
        input  idExBubble, stallCount, flushCount, memTimeout
    );

    modport slave (
        input  idValid, idRs, idRt, idUsesRt,
        input  exMemRead, exRegWrite, exWriteRegister,
        input  branchTaken, memBusy,
        output pcWrite, ifIdWrite,
        output ifIdFlush, idExFlush, exMemFlush,
        output idExBubble, stallCount, flushCount, memTimeout
    );

endinterface

// File: rtl/saturating_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Stall/flush controller: load-use stalls, taken-branch flushes,
// data-memory wait holds with a sticky timeout flag.
module pipeline_hazard_control
    import pipeline_control_pkg::*;
(
    input logic                       clk,
    input logic                       reset,
    pipeline_hazard_control_if.slave  bus
);

    state_t     state;
    state_t     state_next;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;
    logic       pc_write;
    logic       if_id_write;
    logic       flush_all;
    logic       bubble;
    logic [7:0] wait_cnt;
    logic       timeout;

    assign load_use = load_use_hit(
        bus.idValid, bus.idRs, bus.idRt, bus.idUsesRt,
        bus.exMemRead, bus.exRegWrite, bus.exWriteRegister
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // MEM_WAIT with memBusy low falls through to the RUN rules.
    always_comb begin
        state_next  = RUN;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush_all   = 1'b0;
        bubble      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            flush_all   = 1'b1;
        end else if (bus.memBusy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stall_inc   = 1'b1;
            state_next  = MEM_WAIT;
        end else if (bus.branchTaken) begin
            flush_all  = 1'b1;
            flush_inc  = 1'b1;
            state_next = FLUSH;
        end else if (load_use &&
                     (state == RUN || state == MEM_WAIT)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
            stall_inc   = 1'b1;
            state_next  = LOAD_STALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state != MEM_WAIT) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 8'(TIMEOUT_LIMIT)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == MEM_WAIT &&
                wait_cnt == 8'(TIMEOUT_LIMIT - 1)) begin
                timeout <= 1'b1;
            end
        end
    end

    saturating_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (stall_inc),
        .count (bus.stallCount)
    );

    saturating_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (flush_inc),
        .count (bus.flushCount)
    );

    assign bus.pcWrite    = pc_write;
    assign bus.ifIdWrite  = if_id_write;
    assign bus.ifIdFlush  = flush_all;
    assign bus.idExFlush  = flush_all;
    assign bus.exMemFlush = flush_all;
    assign bus.idExBubble = bubble;
    assign bus.memTimeout = timeout;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Scoreboard bench: driver pushes model expectations, monitor compares.
module tb_pipeline_hazard_control;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pipeline_hazard_control_if bus ();

    pipeline_hazard_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pc;
        bit ifid;
        bit fl;
        bit bub;
        int sc;
        int fc;
        bit to;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int passed = 0;

    // Abstract model: waiting on memory, one-shot hazard suppression,
    // wait-cycle tally and the counters.
    bit m_wait = 0;
    bit m_sup = 0;
    int m_wc = 0;
    int m_sc = 0;
    int m_fc = 0;
    bit m_to = 0;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t",
                      n, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic cyc(input bit r, input bit v,
                       input bit [4:0] rs, input bit [4:0] rt,
                       input bit ur, input bit mr, input bit rw,
                       input bit [4:0] wr, input bit bt, input bit mb);
        exp_t e;
        bit lu;
        bit was;
        @(posedge clk);
        #1;
        reset = r;
        bus.idValid = v;
        bus.idRs = rs;
        bus.idRt = rt;
        bus.idUsesRt = ur;
        bus.exMemRead = mr;
        bus.exRegWrite = rw;
        bus.exWriteRegister = wr;
        bus.branchTaken = bt;
        bus.memBusy = mb;
        e.pc = 1; e.ifid = 1; e.fl = 0; e.bub = 0;
        e.sc = m_sc; e.fc = m_fc; e.to = m_to;
        if (r) begin
            e.pc = 0; e.ifid = 0; e.fl = 1;
            e.sc = 0; e.fc = 0; e.to = 0;
            m_wait = 0; m_sup = 0; m_wc = 0;
            m_sc = 0; m_fc = 0; m_to = 0;
        end else begin
            lu = v && mr && rw && wr != 0 &&
                 (wr == rs || (ur && wr == rt));
            was = m_wait;
            if (was && m_wc < 255) begin
                m_wc++;
                if (m_wc == 255) m_to = 1;
            end
            if (mb) begin
                e.pc = 0; e.ifid = 0;
                m_sc = sat(m_sc);
                if (!was) m_wc = 0;
                m_wait = 1; m_sup = 0;
            end else if (bt) begin
                e.fl = 1;
                m_fc = sat(m_fc);
                m_wait = 0; m_sup = 1;
            end else if (lu && !m_sup) begin
                e.pc = 0; e.ifid = 0; e.bub = 1;
                m_sc = sat(m_sc);
                m_wait = 0; m_sup = 1;
            end else begin
                m_wait = 0; m_sup = 0;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic busy();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcWrite", bus.pcWrite, e.pc);
                chk("ifIdWrite", bus.ifIdWrite, e.ifid);
                chk("ifIdFlush", bus.ifIdFlush, e.fl);
                chk("idExFlush", bus.idExFlush, e.fl);
                chk("exMemFlush", bus.exMemFlush, e.fl);
                chk("idExBubble", bus.idExBubble, e.bub);
                chk("stallCount", bus.stallCount, e.sc);
                chk("flushCount", bus.flushCount, e.fc);
                chk("memTimeout", bus.memTimeout, e.to);
            end
        end
    end

    initial begin : driver
        bus.idValid = 0; bus.idRs = 0; bus.idRt = 0;
        bus.idUsesRt = 0; bus.exMemRead = 0;
        bus.exRegWrite = 0; bus.exWriteRegister = 0;
        bus.branchTaken = 0; bus.memBusy = 0;
        repeat (2) idle(1);

        // load-use on rs: single stall cycle
        idle(0);
        cyc(0, 1, 8, 0, 0, 1, 1, 8, 0, 0);
        cyc(0, 1, 8, 0, 0, 1, 1, 8, 0, 0);
        idle(0);
        chk("lu_stallCount", bus.stallCount, 1);

        // register zero never hazards
        idle(1);
        cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(0);
        chk("r0_stallCount", bus.stallCount, 0);

        // branch beats load-use
        idle(1);
        cyc(0, 1, 8, 0, 0, 1, 1, 8, 1, 0);
        idle(0);
        chk("br_flushCount", bus.flushCount, 1);
        chk("br_stallCount", bus.stallCount, 0);

        // memory wait then branch on release
        idle(1);
        repeat (3) busy();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0);
        chk("mw_stallCount", bus.stallCount, 3);
        chk("mw_flushCount", bus.flushCount, 1);

        // long wait trips the sticky timeout
        idle(1);
        repeat (300) busy();
        repeat (3) idle(0);
        chk("to_sticky", bus.memTimeout, 1);

        // reset in the middle of a wait
        idle(1);
        repeat (5) busy();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        idle(0);

        // randomized traffic with rare resets
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0);
        end

        // stall counter saturation
        idle(1);
        repeat (65600) busy();
        idle(0);
        chk("sat_stallCount", bus.stallCount, 65535);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_control.md
PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

Interface
REQ-001 SHALL have these ports: clk  in  1  single system clock, rising-edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 idValid  in  1  decode stage holds a real instruction.
REQ-004 idRs  in  5  decode source register, instruction[25:21].
REQ-005 idRt  in  5  decode second source register, instruction[20:16].
REQ-006 idUsesRt  in  1  decode instruction reads idRt.
REQ-007 exMemRead  in  1  instruction in execute is a load.
REQ-008 exRegWrite  in  1  instruction in execute writes a register.
REQ-009 exWriteRegister  in  5  destination register of execute instruction.
REQ-010 branchTaken  in  1  branch resolved taken in memory stage; held stable while memBusy is high.
REQ-011 memBusy  in  1  data memory wait request.
REQ-012 pcWrite, ifIdWrite  out  1 each  enable PC and IF/ID register update.
REQ-013 ifIdFlush, idExFlush, exMemFlush  out  1 each  clear the named pipeline register to a bubble.
REQ-014 idExBubble  out  1  insert a NOP into ID/EX in place of the decoded instruction.
REQ-015 stallCount, flushCount  out  16 each  saturating event counters.
REQ-016 memTimeout  out  1  sticky memory-wait timeout error.

Function
REQ-017 loadUse SHALL be idValid & exMemRead & exRegWrite & (exWriteRegister != 0) & (exWriteRegister == idRs | (idUsesRt & exWriteRegister == idRt)).
REQ-018 FSM states SHALL be RUN, LOAD_STALL, MEM_WAIT, FLUSH.
REQ-019 Event priority SHALL be reset > memBusy > branchTaken > loadUse.
REQ-020 RUN/FLUSH/LOAD_STALL, memBusy=1: pcWrite=ifIdWrite=0, all flushes and idExBubble=0; next state MEM_WAIT.
REQ-021 RUN/FLUSH/LOAD_STALL, memBusy=0, branchTaken=1: ifIdFlush=idExFlush=exMemFlush=1, pcWrite=ifIdWrite=1; next state FLUSH; flushCount increments.
REQ-022 RUN only, memBusy=0, branchTaken=0, loadUse=1: pcWrite=ifIdWrite=0, idExBubble=1; next state LOAD_STALL; stallCount increments.
REQ-023 LOAD_STALL and FLUSH SHALL ignore loadUse, so a load-use hazard costs exactly one stall cycle; with no other event, outputs are pcWrite=ifIdWrite=1 and the next state is RUN.
REQ-024 MEM_WAIT, memBusy=1: all pipeline outputs held (pcWrite=ifIdWrite=0, no flush or bubble); stallCount increments each cycle.
REQ-025 MEM_WAIT, memBusy=0: outputs and transitions SHALL be identical to RUN for the same inputs, including a pending branchTaken or loadUse.
REQ-026 A wait counter SHALL clear on entry to MEM_WAIT and count MEM_WAIT cycles; when it reaches TIMEOUT_LIMIT (255), memTimeout SHALL set and remain set until reset; FSM behaviour is unchanged.
REQ-027 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-028 All pipeline-control outputs SHALL be combinational from state and inputs, with no cycle of latency; counters and memTimeout are registered.

Reset
REQ-029 While reset is high: state=RUN, counters=0, memTimeout=0, pcWrite=ifIdWrite=0, ifIdFlush=idExFlush=exMemFlush=1, idExBubble=0.
REQ-030 Reset asserted mid-stall or mid-wait SHALL abandon the operation immediately; the first cycle after deassertion is evaluated as RUN.

Structure
REQ-031 Package pipeline_control_pkg SHALL hold the state encoding (RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3), TIMEOUT_LIMIT=255 and ZERO_REGISTER=0.
REQ-032 One sub-module, saturating_counter (16-bit, increment enable, async reset), SHALL be instantiated for stallCount and flushCount.

Verification
REQ-033 Load-use case: exMemRead=1, exRegWrite=1, exWriteRegister=8, idRs=8, idValid=1 -> one cycle with pcWrite=0 and idExBubble=1, then pcWrite=1; stallCount=1.
REQ-034 Register zero: exWriteRegister=0, idRs=0, exMemRead=1 -> no stall; stallCount stays 0.
REQ-035 Simultaneous branch and load-use: branchTaken=1 with a loadUse match -> flushes=1, idExBubble=0, state FLUSH; flushCount=1, stallCount=0.
REQ-036 memBusy high for 3 cycles, then branchTaken on release -> 3 held cycles (stallCount=3), then flush cycle; flushCount=1.
REQ-037 memBusy held for 300 cycles -> memTimeout=1 from wait cycle 255 onward and remains set after memBusy falls; cleared only by reset.
REQ-038 Reset pulse during MEM_WAIT -> counters=0, flushes=1 while reset is high; after release with inputs idle, pcWrite=1 on the first cycle.
